// File: rtl/esn_pkg.sv
// Shared definitions for the ring echo-state reservoir: FSM states,
// ternary input codes and the symmetric saturation limit.
package esn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_DONE = 2'd2
    } esnState_t;

    // Two-bit ternary input codes; 00 and 10 both mean zero.
    localparam logic [1:0] U_PLUS  = 2'b01;
    localparam logic [1:0] U_MINUS = 2'b11;

    // Largest magnitude a cell may hold; the most-negative code is never used.
    function automatic int satLimit(input int dataW);
        return (1 << (dataW - 1)) - 1;
    endfunction

endpackage

// File: rtl/esn_sat_step.sv
// Combinational cell update: optional leak, ternary input step, then
// symmetric clamp. Evaluated two bits wider than the cell so nothing wraps.
module esn_sat_step
    import esn_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter int STEP       = 1,
    parameter int LEAK_SHIFT = 0
)
(
    input  logic [DATA_W-1:0] v,
    input  logic [1:0]        u,
    output logic [DATA_W-1:0] res,
    output logic              sat
);

    localparam int EW  = DATA_W + 2;
    localparam int LIM = satLimit(DATA_W);
    localparam logic signed [EW-1:0] POS_LIM = EW'(LIM);
    localparam logic signed [EW-1:0] NEG_LIM = EW'(-LIM);
    localparam logic signed [EW-1:0] STEP_V  = EW'(STEP);

    logic signed [EW-1:0] vExt;
    logic signed [EW-1:0] leaked;
    logic signed [EW-1:0] stepVal;
    logic signed [EW-1:0] sum;

    // Leak (arithmetic shift floors toward -inf on purpose), add step, clamp.
    always_comb begin
        vExt = {{2{v[DATA_W-1]}}, v};
        if (LEAK_SHIFT == 0) begin
            leaked = vExt;
        end else begin
            leaked = vExt - (vExt >>> LEAK_SHIFT);
        end
        case (u)
            U_PLUS:  stepVal = STEP_V;
            U_MINUS: stepVal = -STEP_V;
            default: stepVal = '0;
        endcase
        sum = leaked + stepVal;
        res = sum[DATA_W-1:0];
        sat = 1'b0;
        if (sum > POS_LIM) begin
            res = POS_LIM[DATA_W-1:0];
            sat = 1'b1;
        end else if (sum < NEG_LIM) begin
            res = NEG_LIM[DATA_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/esn_ring_reservoir.sv
// Ring echo-state reservoir: each update shifts every cell one position
// around the ring through the saturating step, one cell per cycle.
module esn_ring_reservoir
    import esn_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter int N_CELLS    = 8,
    parameter int STEP       = 1,
    parameter int LEAK_SHIFT = 0
)
(
    input  logic                           iClk,
    input  logic                           iRst_n,
    input  logic                           iStart,
    input  logic                           iClr,
    input  logic [2*N_CELLS-1:0]           iU,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [DATA_W*N_CELLS-1:0]      oState,
    output logic [$clog2(N_CELLS+1)-1:0]   oSatCnt
);

    localparam int IDX_W = $clog2(N_CELLS);
    localparam int CNT_W = $clog2(N_CELLS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CELLS - 1);

    esnState_t            state;
    esnState_t            nextState;
    logic [IDX_W-1:0]     idx;
    logic [2*N_CELLS-1:0] uReg;
    logic [DATA_W-1:0]    wrapReg;
    logic [DATA_W-1:0]    cells [N_CELLS];
    logic [DATA_W-1:0]    srcVal;
    logic [DATA_W-1:0]    newVal;
    logic [1:0]           uCur;
    logic                 satHit;
    logic                 accept;
    logic                 clrReq;

    // State register; reset mid-update simply drops back to IDLE.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and control; requests are only looked at while IDLE.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        clrReq    = 1'b0;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iClr) begin
                    clrReq = 1'b1;
                end else if (iStart) begin
                    accept    = 1'b1;
                    nextState = ST_UPD;
                end
            end
            ST_UPD: begin
                oBusy = 1'b1;
                if (idx == '0) begin
                    nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                oBusy     = 1'b1;
                oDone     = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Source is the not-yet-overwritten lower neighbour, or the saved top cell for cell 0.
    always_comb begin
        srcVal = wrapReg;
        if (idx != '0) begin
            srcVal = cells[idx - IDX_W'(1)];
        end
        uCur = uReg[{idx, 1'b0} +: 2];
    end

    esn_sat_step #(
        .DATA_W     (DATA_W),
        .STEP       (STEP),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) uStep (
        .v   (srcVal),
        .u   (uCur),
        .res (newVal),
        .sat (satHit)
    );

    // Datapath: clear, capture on accept, then write one cell per UPD cycle.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < N_CELLS; k++) begin
                cells[k] <= '0;
            end
            idx     <= '0;
            uReg    <= '0;
            wrapReg <= '0;
            oSatCnt <= '0;
        end else if (clrReq) begin
            for (int k = 0; k < N_CELLS; k++) begin
                cells[k] <= '0;
            end
            oSatCnt <= '0;
        end else if (accept) begin
            uReg    <= iU;
            wrapReg <= cells[N_CELLS-1];
            oSatCnt <= '0;
            idx     <= IDX_LAST;
        end else if (state == ST_UPD) begin
            cells[idx] <= newVal;
            if (satHit) begin
                oSatCnt <= oSatCnt + CNT_W'(1);
            end
            idx <= idx - IDX_W'(1);
        end
    end

    // Flatten the cell array onto the output bus.
    always_comb begin
        oState = '0;
        for (int k = 0; k < N_CELLS; k++) begin
            oState[DATA_W*k +: DATA_W] = cells[k];
        end
    end

endmodule
